regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read integer register file.
- Configurable read and write port counts.
- Per-register pending (scoreboard) bits for in-flight producers.
- Sequential bulk-clear engine with busy handshake.
- Debug read port.
- Sits in the decode/writeback stage of the processor datapath.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDRESS_WIDTH, 5, register address width.
- NUM_REGS, 32, number of registers; must be <= 2**ADDRESS_WIDTH.
- NUM_RD, 2, read ports (1..4).
- NUM_WR, 2, write ports (1..2); port 1 is the late load-return port.
- ZERO_REG, 1, 1 = register 0 hardwired to zero.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDRESS_WIDTH  write addresses, port p at bits [p*AW +: AW].
- wr_data  in  NUM_WR*DATA_WIDTH  write data, packed likewise.
- rd_addr  in  NUM_RD*ADDRESS_WIDTH  read addresses.
- rd_data  out  NUM_RD*DATA_WIDTH  combinational read data.
- rd_pend  out  NUM_RD  pending bit of each addressed register.
- sb_set_en  in  1  mark sb_set_addr pending (producer issued).
- sb_set_addr  in  ADDRESS_WIDTH  register to mark.
- clr_req  in  1  start bulk clear (single-cycle pulse sufficient).
- clr_busy  out  1  high while the clear engine walks.
- dbg_addr  in  ADDRESS_WIDTH  debug read address.
- dbg_data  out  DATA_WIDTH  combinational debug read, never bypassed.

Behaviour:
- Reset: rst=1 at a clock edge zeroes all registers and all pending bits, forces the FSM to IDLE and the clear counter to 0.
  - After reset: rd_data=0, rd_pend=0, clr_busy=0, dbg_data=0.
  - rst overrides every other input in the same cycle.
- Writes:
  - wr_en[p]=1 writes wr_data[p] into wr_addr[p] at the edge.
  - Two ports to the same address in one cycle: the highest-indexed port wins.
  - Addresses >= NUM_REGS are ignored.
  - With ZERO_REG=1, writes to register 0 are dropped, register 0 reads 0 and is never pending.
- Reads:
  - rd_data[r] = register[rd_addr[r]] combinationally.
  - Address >= NUM_REGS reads 0.
- Scoreboard:
  - A write to register n clears pend[n] at the edge.
  - sb_set_en sets pend[sb_set_addr] at the edge.
  - Set and write to the same register in one cycle: set wins, so the register stays pending.
  - rd_pend[r] = pend[rd_addr[r]], registered state, no bypass.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1.
  - In CLEAR, each cycle zeroes register[cnt] and pend[cnt], then cnt increments.
  - When cnt = NUM_REGS-1 is cleared, the FSM returns to IDLE with cnt=0.
  - Total NUM_REGS cycles; clr_busy=1 exactly in those cycles, first busy cycle is the one after the clr_req edge.
  - Write ports and sb_set_en are ignored while clr_busy=1.
  - clr_req while busy is ignored.
  - Reads during the walk return the current, partially cleared contents.
  - rst mid-clear ends the walk immediately, with the normal reset result.
- Widths: no arithmetic; cnt is ADDRESS_WIDTH+1 bits to cover NUM_REGS=2**ADDRESS_WIDTH without wrap.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Write-first bypass: a read whose address matches an active, non-dropped write in the same cycle returns that write's data (highest port wins).
  - rd_pend is not bypassed.
  - No bypass while clr_busy=1.
- Undefined: reads return the stored value; new data is visible the cycle after the write.

Decomposition:
- Package regfile_pkg:
  - clr_state_t enum {CLR_IDLE, CLR_WALK}.
  - Default width localparams.
  - Helper function for port slice indexing.
- Sub-module regfile_scoreboard: pending-bit array, set/clear priority, per-port rd_pend lookup, clear-by-index input driven by the walk.

Test Plan:
- Reset, then read all registers on every port -> all rd_data=0, rd_pend=0, clr_busy=0.
- Same cycle: wr port0 r5=0x11, port1 r5=0x22 -> next cycle r5 reads 0x22; write r0=0xFFFF -> r0 reads 0.
- sb_set r7, two idle cycles -> rd_pend=1; write r7=0xA5 -> pend clears next cycle; set and write r9 in the same cycle -> r9 stays pending, holds new data.
- Fill r1..r31, pulse clr_req -> clr_busy high exactly 32 cycles; write to r3 during the walk is lost; all registers read 0 afterwards.
- rst asserted at walk cycle 10 -> next cycle clr_busy=0, all registers 0, a new clr_req is accepted.
- Same-cycle write r4=0x1234 with rd_addr r4:
  - With REGFILE_MP_BYPASS_EN: rd_data=0x1234 that cycle.
  - Without: old value that cycle, 0x1234 the next.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types, default widths and slice helper for the multi-port register file.
// The optional write-first bypass in regfile_mp is enabled by REGFILE_MP_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_NUM_REGS      = 32;
  localparam int DEF_NUM_RD        = 2;
  localparam int DEF_NUM_WR        = 2;
  localparam int DEF_ZERO_REG      = 1;

  typedef enum logic [0:0] {
    CLR_IDLE = 1'b0,
    CLR_WALK = 1'b1
  } clr_state_t;

  // Low bit of port p inside a packed multi-port bus whose fields are width bits wide.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle of the multi-port register file: write ports, read ports,
// scoreboard set, bulk-clear handshake and debug read.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int NUM_WR        = DEF_NUM_WR
) ();

  logic [NUM_WR-1:0]               wr_en;
  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data;
  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]    rd_data;
  logic [NUM_RD-1:0]               rd_pend;
  logic                            sb_set_en;
  logic [ADDRESS_WIDTH-1:0]        sb_set_addr;
  logic                            clr_req;
  logic                            clr_busy;
  logic [ADDRESS_WIDTH-1:0]        dbg_addr;
  logic [DATA_WIDTH-1:0]           dbg_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, clr_req, dbg_addr,
    input  rd_data, rd_pend, clr_busy, dbg_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, clr_req, dbg_addr,
    output rd_data, rd_pend, clr_busy, dbg_data
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: writes clear, producer issue sets (set wins),
// and the bulk-clear walk wipes one entry per cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int NUM_WR        = DEF_NUM_WR,
  parameter int ZERO_REG      = DEF_ZERO_REG
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               wr_ok,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic                            set_en,
  input  logic [ADDRESS_WIDTH-1:0]        set_addr,
  input  logic                            clr_en,
  input  logic [ADDRESS_WIDTH-1:0]        clr_idx,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]               rd_pend
);

  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW:0] REGS_W = (AW+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] pend;
  logic                set_ok;

  assign set_ok = set_en && ({1'b0, set_addr} < REGS_W) &&
                  !((ZERO_REG != 0) && (set_addr == '0));

  // The set is applied after the write clears so a same-cycle set keeps the entry pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (clr_en) begin
      pend[clr_idx] <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p]) begin
          pend[wr_addr[slice_lo(p, AW) +: AW]] <= 1'b0;
        end
      end
      if (set_ok) begin
        pend[set_addr] <= 1'b1;
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[slice_lo(r, AW) +: AW];
    assign rd_pend[r] = ({1'b0, ra} < REGS_W) ? pend[ra] : 1'b0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with pending scoreboard, bulk-clear walk
// and debug read. Define REGFILE_MP_BYPASS_EN for write-first read bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int NUM_WR        = DEF_NUM_WR,
  parameter int ZERO_REG      = DEF_ZERO_REG
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW:0] REGS_W   = (AW+1)'(NUM_REGS);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_REGS - 1);

  logic [DW-1:0] regs [NUM_REGS];
  clr_state_t    state;
  logic [AW:0]   cnt;
  logic          busy;

  logic [NUM_WR-1:0] wr_ok;
  logic [AW-1:0]     wr_addr_a [NUM_WR];
  logic [DW-1:0]     wr_data_a [NUM_WR];

  assign busy         = (state == CLR_WALK);
  assign bus.clr_busy = busy;

  // A write only lands when idle, in range and not aimed at a hardwired zero register.
  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign wr_addr_a[p] = bus.wr_addr[slice_lo(p, AW) +: AW];
    assign wr_data_a[p] = bus.wr_data[slice_lo(p, DW) +: DW];
    assign wr_ok[p]     = bus.wr_en[p] && !busy &&
                          ({1'b0, wr_addr_a[p]} < REGS_W) &&
                          !((ZERO_REG != 0) && (wr_addr_a[p] == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (bus.clr_req) begin
            state <= CLR_WALK;
            cnt   <= '0;
          end
        end
        CLR_WALK: begin
          if (cnt == LAST_IDX) begin
            state <= CLR_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + (AW+1)'(1);
          end
        end
        default: begin
          state <= CLR_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Later ports overwrite earlier ones, so the highest-indexed port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[cnt[AW-1:0]] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p]) begin
          regs[wr_addr_a[p]] <= wr_data_a[p];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rv;
    assign ra = bus.rd_addr[slice_lo(r, AW) +: AW];
    always_comb begin
      rv = ({1'b0, ra} < REGS_W) ? regs[ra] : '0;
`ifdef REGFILE_MP_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_ok[p] && (wr_addr_a[p] == ra)) begin
          rv = wr_data_a[p];
        end
      end
`endif
    end
    assign bus.rd_data[slice_lo(r, DW) +: DW] = rv;
  end

  assign bus.dbg_data = ({1'b0, bus.dbg_addr} < REGS_W) ? regs[bus.dbg_addr] : '0;

  regfile_scoreboard #(
    .ADDRESS_WIDTH (AW),
    .NUM_REGS      (NUM_REGS),
    .NUM_RD        (NUM_RD),
    .NUM_WR        (NUM_WR),
    .ZERO_REG      (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_ok    (wr_ok),
    .wr_addr  (bus.wr_addr),
    .set_en   (bus.sb_set_en && !busy),
    .set_addr (bus.sb_set_addr),
    .clr_en   (busy),
    .clr_idx  (cnt[AW-1:0]),
    .rd_addr  (bus.rd_addr),
    .rd_pend  (bus.rd_pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes model expectations, a negedge
// monitor pops and compares. Model follows REGFILE_MP_BYPASS_EN like the design.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b1;
  logic rst;

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .NUM_REGS      (NR),
    .NUM_RD        (2),
    .NUM_WR        (2),
    .ZERO_REG      (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [63:0] rd;
    logic [1:0]  pend;
    logic        busy;
    logic [31:0] dbg;
  } exp_t;

  exp_t exp_q[$];

  logic        t_rst;
  logic [1:0]  t_wr_en;
  logic [4:0]  t_wa [2];
  logic [31:0] t_wd [2];
  logic [4:0]  t_ra [2];
  logic        t_sb;
  logic [4:0]  t_sba;
  logic        t_clr;
  logic [4:0]  t_dbg;
  bit          chk_en;

  logic [31:0] m_mem  [NR];
  bit          m_pend [NR];
  bit          m_walk;
  int          m_pos;

  int checks = 0;
  int passed = 0;

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  task automatic check_output(input exp_t e);
    for (int r = 0; r < 2; r++) begin
      compare($sformatf("rd_data%0d", r), bus.rd_data[r*32 +: 32], e.rd[r*32 +: 32]);
      compare($sformatf("rd_pend%0d", r), {31'd0, bus.rd_pend[r]}, {31'd0, e.pend[r]});
    end
    compare("clr_busy", {31'd0, bus.clr_busy}, {31'd0, e.busy});
    compare("dbg_data", bus.dbg_data, e.dbg);
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) check_output(e);
      end
    end
  end

  function automatic void idle();
    t_rst   = 1'b0;
    t_wr_en = 2'b00;
    t_sb    = 1'b0;
    t_clr   = 1'b0;
  endfunction

  task automatic apply_stimulus();
    exp_t        e;
    logic [31:0] v;
    rst             = t_rst;
    bus.wr_en       = t_wr_en;
    bus.wr_addr     = {t_wa[1], t_wa[0]};
    bus.wr_data     = {t_wd[1], t_wd[0]};
    bus.rd_addr     = {t_ra[1], t_ra[0]};
    bus.sb_set_en   = t_sb;
    bus.sb_set_addr = t_sba;
    bus.clr_req     = t_clr;
    bus.dbg_addr    = t_dbg;

    e.chk  = chk_en;
    e.busy = m_walk;
    for (int r = 0; r < 2; r++) begin
      v = m_mem[t_ra[r]];
`ifdef REGFILE_MP_BYPASS_EN
      if (!m_walk)
        for (int p = 0; p < 2; p++)
          if (t_wr_en[p] && t_wa[p] != 0 && t_wa[p] == t_ra[r]) v = t_wd[p];
`endif
      e.rd[r*32 +: 32] = v;
      e.pend[r]        = m_pend[t_ra[r]];
    end
    e.dbg = m_mem[t_dbg];
    exp_q.push_back(e);

    if (t_rst) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_walk = 1'b0;
      m_pos  = 0;
    end else if (m_walk) begin
      m_mem[m_pos]  = '0;
      m_pend[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == NR) begin
        m_walk = 1'b0;
        m_pos  = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (t_wr_en[p] && t_wa[p] != 0) begin
          m_mem[t_wa[p]]  = t_wd[p];
          m_pend[t_wa[p]] = 1'b0;
        end
      end
      if (t_sb && t_sba != 0) m_pend[t_sba] = 1'b1;
      if (t_clr) begin
        m_walk = 1'b1;
        m_pos  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    t_wr_en = 2'b01;
    t_wa[0] = a;
    t_wd[0] = d;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_walk = 1'b0;
    m_pos  = 0;
    idle();
    for (int p = 0; p < 2; p++) begin
      t_wa[p] = '0;
      t_wd[p] = '0;
      t_ra[p] = '0;
    end
    t_sba  = '0;
    t_dbg  = '0;

    chk_en = 1'b0;
    t_rst  = 1'b1;
    apply_stimulus();
    chk_en = 1'b1;
    idle();

    for (int i = 0; i < 16; i++) begin
      t_ra[0] = 5'(i);
      t_ra[1] = 5'(31 - i);
      t_dbg   = 5'(2 * i);
      apply_stimulus();
    end

    t_wr_en = 2'b11;
    t_wa[0] = 5'd5; t_wd[0] = 32'h11;
    t_wa[1] = 5'd5; t_wd[1] = 32'h22;
    t_ra[0] = 5'd5; t_ra[1] = 5'd0;
    apply_stimulus();
    idle();
    apply_stimulus();
    write1(5'd0, 32'hFFFF);
    apply_stimulus();
    idle();
    t_dbg = 5'd0;
    apply_stimulus();

    t_sb = 1'b1; t_sba = 5'd7;
    t_ra[0] = 5'd7; t_ra[1] = 5'd7;
    apply_stimulus();
    idle();
    apply_stimulus();
    apply_stimulus();
    write1(5'd7, 32'hA5);
    apply_stimulus();
    idle();
    apply_stimulus();
    write1(5'd9, 32'h99);
    t_sb = 1'b1; t_sba = 5'd9;
    t_ra[0] = 5'd9; t_ra[1] = 5'd7;
    apply_stimulus();
    idle();
    t_dbg = 5'd9;
    apply_stimulus();

    for (int i = 1; i < NR; i += 2) begin
      t_wr_en = (i + 1 < NR) ? 2'b11 : 2'b01;
      t_wa[0] = 5'(i);
      t_wa[1] = 5'(i + 1);
      t_wd[0] = 32'(i) * 32'h0101_0101;
      t_wd[1] = 32'(i + 1) * 32'h0101_0101;
      t_ra[0] = 5'(i);
      apply_stimulus();
    end
    idle();
    t_clr = 1'b1;
    apply_stimulus();
    idle();
    for (int k = 0; k < 34; k++) begin
      if (k == 3) write1(5'd3, 32'hDEAD);
      t_ra[0] = 5'd3;
      t_ra[1] = 5'(k);
      t_dbg   = 5'(31 - k);
      apply_stimulus();
      idle();
    end
    for (int i = 0; i < 16; i++) begin
      t_ra[0] = 5'(i);
      t_ra[1] = 5'(i + 16);
      apply_stimulus();
    end

    write1(5'd2, 32'h2222);
    apply_stimulus();
    write1(5'd20, 32'h2020);
    apply_stimulus();
    idle();
    t_clr = 1'b1;
    apply_stimulus();
    idle();
    t_ra[0] = 5'd2; t_ra[1] = 5'd20;
    repeat (10) apply_stimulus();
    t_rst = 1'b1;
    apply_stimulus();
    idle();
    apply_stimulus();
    t_clr = 1'b1;
    apply_stimulus();
    idle();
    repeat (33) apply_stimulus();

    write1(5'd4, 32'h1111);
    apply_stimulus();
    write1(5'd4, 32'h1234);
    t_ra[0] = 5'd4; t_ra[1] = 5'd4;
    apply_stimulus();
    idle();
    apply_stimulus();

    for (int n = 0; n < 400; n++) begin
      t_wr_en = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        t_wa[p] = 5'($urandom);
        t_wd[p] = $urandom;
        t_ra[p] = ($urandom_range(0, 3) == 0) ? t_wa[p] : 5'($urandom);
      end
      t_sb  = ($urandom_range(0, 3) == 0);
      t_sba = 5'($urandom);
      t_clr = ($urandom_range(0, 49) == 0);
      t_rst = ($urandom_range(0, 149) == 0);
      t_dbg = 5'($urandom);
      apply_stimulus();
    end
    idle();
    apply_stimulus();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
